// File: rtl/base_pipeline_pkg.sv
// Shared definitions for the base_pipeline RV32 core: ALU operation
// encodings, RV32 opcode/funct constants and the pipeline register layouts.
package base_pipeline_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND,
    ALU_MUL,
    ALU_PASSB   // result = b, used by LUI
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  // rs1/rs2 hold the *effective* source registers: 0 when the operand is an
  // immediate or unused, so forwarding can never hit on them.
  typedef struct packed {
    logic              valid;
    alu_op_e           op;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
  } id_ex_t;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   result;
  } ex_wb_t;

endpackage

// File: rtl/base_pipeline_alu.sv
// Combinational RV32 ALU (base integer ops + MUL low word).
//   op_i      operation select
//   a_i, b_i  operands
//   result_o  32-bit wraparound result
module alu
  import base_pipeline_pkg::*;
(
  input  alu_op_e         op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] result_o
);

  logic [4:0] shamt;
  assign shamt = b_i[4:0];

  always_comb begin
    // NOTE: default assignment first so no path leaves result_o unassigned,
    // which would otherwise infer a latch.
    result_o = '0;
    case (op_i)
      ALU_ADD:   result_o = a_i + b_i;
      ALU_SUB:   result_o = a_i - b_i;
      ALU_SLL:   result_o = a_i << shamt;
      ALU_SLT:   result_o = {31'b0, $signed(a_i) < $signed(b_i)};
      ALU_SLTU:  result_o = {31'b0, a_i < b_i};
      ALU_XOR:   result_o = a_i ^ b_i;
      ALU_SRL:   result_o = a_i >> shamt;
      ALU_SRA:   result_o = $signed(a_i) >>> shamt;
      ALU_OR:    result_o = a_i | b_i;
      ALU_AND:   result_o = a_i & b_i;
      ALU_MUL:   result_o = a_i * b_i;   // low 32 bits of the product
      ALU_PASSB: result_o = b_i;
      default:   result_o = '0;
    endcase
  end

endmodule

// File: rtl/base_pipeline_register_file.sv
// 32x32 integer register file with two combinational read ports and one
// write port. Reads see a same-cycle write (write-through); x0 reads 0 and is
// never written.
//   clk_i              clock
//   raddr1_i/raddr2_i  read addresses, rdata1_o/rdata2_o read data
//   we_i/waddr_i/wdata_i  write port, committed on the rising edge
module register_file
  import base_pipeline_pkg::*;
(
  input  logic              clk_i,
  input  logic [REG_AW-1:0] raddr1_i,
  input  logic [REG_AW-1:0] raddr2_i,
  output logic [XLEN-1:0]   rdata1_o,
  output logic [XLEN-1:0]   rdata2_o,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [XLEN-1:0]   wdata_i
);

  logic [XLEN-1:0] data [32];
  logic            wr_hit;

  assign wr_hit = we_i && (waddr_i != '0);

  // NOTE: the array has no reset so contents loaded before reset survive it
  // and the storage maps onto plain RAM/flops without a reset tree.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk_i) begin
    if (wr_hit) data[waddr_i] <= wdata_i;
  end

  always_comb begin
    if (raddr1_i == '0)                   rdata1_o = '0;
    else if (wr_hit && waddr_i == raddr1_i) rdata1_o = wdata_i;
    else                                  rdata1_o = data[raddr1_i];
  end

  always_comb begin
    if (raddr2_i == '0)                   rdata2_o = '0;
    else if (wr_hit && waddr_i == raddr2_i) rdata2_o = wdata_i;
    else                                  rdata2_o = data[raddr2_i];
  end

endmodule

// File: rtl/instruction_rom_wrapper.sv
// Word-addressed instruction ROM with a synchronous read port. dout is the
// word at addr one cycle after addr is presented and is 0 out of reset.
// The load port lets a system writer program the contents; the core ties
// it off.
//   clk, rst          clock, async active-high reset of dout
//   en, addr, dout    read enable, byte address, read data
//   load_en/addr/data programming write port
module instruction_rom_wrapper #(
  parameter int unsigned AW = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] addr,
  output logic [31:0] dout,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data
);

  logic [31:0] mem [2**AW];
  logic        unused_addr_bits;

  // Only the word index within the array is decoded; the rest aliases.
  assign unused_addr_bits = ^{addr[31:AW+2], addr[1:0],
                              load_addr[31:AW+2], load_addr[1:0]};

  always_ff @(posedge clk) begin
    if (load_en) mem[load_addr[AW+1:2]] <= load_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     dout <= '0;
    else if (en) dout <= mem[addr[AW+1:2]];
  end

endmodule

// File: rtl/base_pipeline.sv
// Minimal in-order 4-stage RV32 integer core (IF, ID, EX, WB) executing
// register/immediate ALU ops, LUI and MUL. No stalls: distance-1 hazards are
// resolved by EX forwarding, distance-2 by register-file write-through.
//   clk  clock, all state on the rising edge
//   rst  asynchronous active-high reset
module base_pipeline
  import base_pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic clk,
  input  logic rst
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr;
  logic        if_valid_q;   // ROM output holds a fetched word (IF/ID valid)
  id_ex_t      id_ex_q, id_ex_d;
  ex_wb_t      ex_wb_q, ex_wb_d;

  // IF ---------------------------------------------------------------------
  assign pc_d = pc_q + 32'd4;

  instruction_rom_wrapper instruction_rom0 (
    .clk       (clk),
    .rst       (rst),
    .en        (1'b1),
    .addr      (pc_q),
    .dout      (instr),
    .load_en   (1'b0),
    .load_addr (32'h0),
    .load_data (32'h0)
  );

  // ID ---------------------------------------------------------------------
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2, rs1_eff, rs2_eff;
  logic        dec_legal, dec_use_imm, dec_use_rs1;
  alu_op_e     dec_op;
  logic [31:0] dec_imm, rf_rdata1, rf_rdata2;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  always_comb begin
    dec_legal   = 1'b0;
    dec_op      = ALU_ADD;
    dec_use_imm = 1'b0;
    dec_use_rs1 = 1'b1;
    dec_imm     = {{20{instr[31]}}, instr[31:20]};
    case (opcode)
      OPC_OP: begin
        if (funct7 == F7_BASE) begin
          dec_legal = 1'b1;
          case (funct3)
            F3_ADD:  dec_op = ALU_ADD;
            F3_SLL:  dec_op = ALU_SLL;
            F3_SLT:  dec_op = ALU_SLT;
            F3_SLTU: dec_op = ALU_SLTU;
            F3_XOR:  dec_op = ALU_XOR;
            F3_SR:   dec_op = ALU_SRL;
            F3_OR:   dec_op = ALU_OR;
            default: dec_op = ALU_AND;
          endcase
        end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
          dec_legal = 1'b1;
          dec_op    = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == F3_SR) begin
          dec_legal = 1'b1;
          dec_op    = ALU_SRA;
        end else if (funct7 == F7_MULDIV && funct3 == F3_ADD) begin
          dec_legal = 1'b1;
          dec_op    = ALU_MUL;
        end
      end
      OPC_OP_IMM: begin
        dec_use_imm = 1'b1;
        dec_legal   = 1'b1;
        case (funct3)
          F3_ADD:  dec_op = ALU_ADD;
          F3_SLT:  dec_op = ALU_SLT;
          F3_SLTU: dec_op = ALU_SLTU;
          F3_XOR:  dec_op = ALU_XOR;
          F3_OR:   dec_op = ALU_OR;
          F3_AND:  dec_op = ALU_AND;
          F3_SLL: begin
            dec_op    = ALU_SLL;
            dec_legal = (funct7 == F7_BASE);
          end
          default: begin  // F3_SR: funct7 selects logical vs arithmetic
            dec_op    = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            dec_legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          end
        endcase
      end
      OPC_LUI: begin
        dec_legal   = 1'b1;
        dec_op      = ALU_PASSB;
        dec_use_imm = 1'b1;
        dec_use_rs1 = 1'b0;
        dec_imm     = {instr[31:12], 12'h000};
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Unused source fields read x0 so they can never match a forwarding rd.
  assign rs1_eff = dec_use_rs1 ? rs1 : 5'd0;
  assign rs2_eff = dec_use_imm ? 5'd0 : rs2;

  register_file register_file0 (
    .clk_i    (clk),
    .raddr1_i (rs1_eff),
    .raddr2_i (rs2_eff),
    .rdata1_o (rf_rdata1),
    .rdata2_o (rf_rdata2),
    .we_i     (ex_wb_q.valid),
    .waddr_i  (ex_wb_q.rd),
    .wdata_i  (ex_wb_q.result)
  );

  always_comb begin
    id_ex_d.valid = if_valid_q && dec_legal;
    id_ex_d.op    = dec_op;
    id_ex_d.rd    = rd;
    id_ex_d.rs1   = rs1_eff;
    id_ex_d.rs2   = rs2_eff;
    id_ex_d.a     = rf_rdata1;
    id_ex_d.b     = dec_use_imm ? dec_imm : rf_rdata2;
  end

  // EX ---------------------------------------------------------------------
  logic        fwd_ok;
  logic [31:0] ex_a, ex_b, ex_result;

  assign fwd_ok = ex_wb_q.valid && (ex_wb_q.rd != 5'd0);
  assign ex_a   = (fwd_ok && ex_wb_q.rd == id_ex_q.rs1) ? ex_wb_q.result : id_ex_q.a;
  assign ex_b   = (fwd_ok && ex_wb_q.rd == id_ex_q.rs2) ? ex_wb_q.result : id_ex_q.b;

  alu alu0 (
    .op_i     (id_ex_q.op),
    .a_i      (ex_a),
    .b_i      (ex_b),
    .result_o (ex_result)
  );

  always_comb begin
    ex_wb_d.valid  = id_ex_q.valid;
    ex_wb_d.rd     = id_ex_q.rd;
    ex_wb_d.result = ex_result;
  end

  // Pipeline registers; reset turns every stage into a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b0;
      id_ex_q    <= '0;
      ex_wb_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      if_valid_q <= 1'b1;
      id_ex_q    <= id_ex_d;
      ex_wb_q    <= ex_wb_d;
    end
  end

endmodule

// File: tb/tb_base_pipeline.sv
module tb_base_pipeline;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  base_pipeline #(.RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst)
  );

  typedef struct {
    int          idx;
    logic [31:0] val;
  } exp_t;

  int          checks   = 0;
  int          failures = 0;
  exp_t        sb[$];
  logic [31:0] prog[$];
  logic [31:0] model[32];

  function automatic logic [31:0] rtype(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] itype(logic [11:0] imm, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] lui(logic [19:0] imm, logic [4:0] rd);
    return {imm, rd, 7'b0110111};
  endfunction

  // Hold reset, preload data[i]=i, load prog into the ROM (rest zero).
  task automatic setup();
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      dut.register_file0.data[i] = 32'(i);
      model[i] = 32'(i);
    end
    for (int i = 0; i < 64; i++)
      dut.instruction_rom0.mem[i] = (i < prog.size()) ? prog[i] : 32'h0;
    @(negedge clk);
  endtask

  task automatic release_and_run(input int n);
    rst = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic push_model();
    exp_t e;
    for (int i = 0; i < 32; i++) begin
      e.idx = i;
      e.val = model[i];
      sb.push_back(e);
    end
  endtask

  task automatic test_reset();
    prog = {};
    setup();
    checks++;
    if (dut.pc_q !== 32'h0) begin
      failures++; $display("FAIL reset_pc: got %h expected %h", dut.pc_q, 32'h0);
    end
    checks++;
    if (dut.instruction_rom0.dout !== 32'h0) begin
      failures++; $display("FAIL reset_rom_dout: got %h expected %h", dut.instruction_rom0.dout, 32'h0);
    end
    checks++;
    if ({dut.if_valid_q, dut.id_ex_q.valid, dut.ex_wb_q.valid} !== 3'b000) begin
      failures++;
      $display("FAIL reset_valids: got %b expected 000",
               {dut.if_valid_q, dut.id_ex_q.valid, dut.ex_wb_q.valid});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (dut.pc_q !== 32'h4) begin
      failures++; $display("FAIL first_pc_step: got %h expected %h", dut.pc_q, 32'h4);
    end
  endtask

  task automatic test_mul();
    exp_t e;
    prog = {rtype(7'b0000001, 5'd3, 5'd2, 3'd0, 5'd1),
            rtype(7'b0000001, 5'd4, 5'd3, 3'd0, 5'd2),
            rtype(7'b0000001, 5'd5, 5'd4, 3'd0, 5'd3)};
    setup();
    model[1] = 32'd6; model[2] = 32'd12; model[3] = 32'd20;
    push_model();
    release_and_run(13);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (dut.register_file0.data[e.idx] !== e.val) begin
        failures++;
        $display("FAIL mul x%0d: got %h expected %h", e.idx, dut.register_file0.data[e.idx], e.val);
      end
    end
  endtask

  task automatic test_dep_chain();
    exp_t e;
    prog = {rtype(7'b0, 5'd3, 5'd2, 3'd0, 5'd1),
            rtype(7'b0, 5'd1, 5'd1, 3'd0, 5'd4),
            rtype(7'b0, 5'd1, 5'd4, 3'd0, 5'd5)};
    setup();
    model[1] = 32'd5; model[4] = 32'd10; model[5] = 32'd15;
    push_model();
    release_and_run(10);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (dut.register_file0.data[e.idx] !== e.val) begin
        failures++;
        $display("FAIL dep_chain x%0d: got %h expected %h", e.idx, dut.register_file0.data[e.idx], e.val);
      end
    end
  endtask

  task automatic test_x0_write();
    exp_t e;
    prog = {itype(12'd7, 5'd0, 3'd0, 5'd0),
            rtype(7'b0, 5'd0, 5'd0, 3'd0, 5'd6)};
    setup();
    model[0] = 32'd0; model[6] = 32'd0;
    push_model();
    release_and_run(10);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (dut.register_file0.data[e.idx] !== e.val) begin
        failures++;
        $display("FAIL x0_write x%0d: got %h expected %h", e.idx, dut.register_file0.data[e.idx], e.val);
      end
    end
  endtask

  task automatic test_imm_shift_compare();
    exp_t e;
    prog = {itype(12'hFFD, 5'd2, 3'd0, 5'd7),                 // addi x7,x2,-3
            itype({7'b0100000, 5'd1}, 5'd7, 3'd5, 5'd8),      // srai x8,x7,1
            rtype(7'b0, 5'd7, 5'd2, 3'd3, 5'd9),              // sltu x9,x2,x7
            lui(20'h12345, 5'd10),                            // lui x10
            rtype(7'b0100000, 5'd5, 5'd3, 3'd0, 5'd11),       // sub x11,x3,x5
            rtype(7'b0, 5'd2, 5'd3, 3'd1, 5'd12),             // sll x12,x3,x2
            rtype(7'b0, 5'd28, 5'd7, 3'd5, 5'd13),            // srl x13,x7,x28
            rtype(7'b0100000, 5'd28, 5'd7, 3'd5, 5'd14),      // sra x14,x7,x28
            rtype(7'b0, 5'd6, 5'd5, 3'd4, 5'd15),             // xor x15,x5,x6
            rtype(7'b0, 5'd2, 5'd7, 3'd2, 5'd16),             // slt x16,x7,x2
            rtype(7'b0, 5'd10, 5'd4, 3'd6, 5'd17),            // or x17,x4,x10
            rtype(7'b0, 5'd11, 5'd31, 3'd7, 5'd18),           // and x18,x31,x11
            itype(12'h000, 5'd7, 3'd2, 5'd19),                // slti x19,x7,0
            itype(12'hFFF, 5'd2, 3'd3, 5'd20),                // sltiu x20,x2,-1
            itype(12'hFFF, 5'd5, 3'd4, 5'd21),                // xori x21,x5,-1
            itype(12'h003, 5'd4, 3'd6, 5'd22),                // ori x22,x4,3
            itype(12'h00F, 5'd31, 3'd7, 5'd23),               // andi x23,x31,15
            itype(12'h004, 5'd3, 3'd1, 5'd24),                // slli x24,x3,4
            itype(12'h01F, 5'd7, 3'd5, 5'd25),                // srli x25,x7,31
            itype(12'h021, 5'd0, 3'd0, 5'd27),                // addi x27,x0,33
            rtype(7'b0, 5'd27, 5'd3, 3'd1, 5'd26),            // sll x26,x3,x27
            rtype(7'b0000001, 5'd7, 5'd7, 3'd0, 5'd30),       // mul x30,x7,x7
            rtype(7'b0, 5'd7, 5'd2, 3'd2, 5'd29)};            // slt x29,x2,x7
    setup();
    model[7]  = 32'hFFFFFFFF; model[8]  = 32'hFFFFFFFF; model[9]  = 32'd1;
    model[10] = 32'h12345000; model[11] = 32'hFFFFFFFE; model[12] = 32'd12;
    model[13] = 32'h0000000F; model[14] = 32'hFFFFFFFF; model[15] = 32'd3;
    model[16] = 32'd1;        model[17] = 32'h12345004; model[18] = 32'd30;
    model[19] = 32'd1;        model[20] = 32'd1;        model[21] = 32'hFFFFFFFA;
    model[22] = 32'd7;        model[23] = 32'd15;       model[24] = 32'd48;
    model[25] = 32'd1;        model[27] = 32'd33;       model[26] = 32'd6;
    model[30] = 32'd1;        model[29] = 32'd0;
    push_model();
    release_and_run(32);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (dut.register_file0.data[e.idx] !== e.val) begin
        failures++;
        $display("FAIL imm_alu x%0d: got %h expected %h", e.idx, dut.register_file0.data[e.idx], e.val);
      end
    end
  endtask

  task automatic test_zero_words();
    exp_t e;
    prog = {};
    setup();
    push_model();
    release_and_run(20);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (dut.register_file0.data[e.idx] !== e.val) begin
        failures++;
        $display("FAIL zero_words x%0d: got %h expected %h", e.idx, dut.register_file0.data[e.idx], e.val);
      end
    end
  endtask

  task automatic test_illegal_words();
    exp_t e;
    prog = {32'hFFFFFFFF,
            rtype(7'b0100000, 5'd2, 5'd3, 3'd1, 5'd5),        // alt funct7 on SLL
            itype({7'b0100000, 5'd1}, 5'd3, 3'd1, 5'd6),      // slli, bad funct7
            rtype(7'b0000001, 5'd2, 5'd3, 3'd3, 5'd7),        // mulhu, unsupported
            32'h00208463,                                     // branch opcode
            itype({7'b0000001, 5'd1}, 5'd3, 3'd5, 5'd8)};     // srli, bad funct7
    setup();
    push_model();
    release_and_run(14);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (dut.register_file0.data[e.idx] !== e.val) begin
        failures++;
        $display("FAIL illegal_words x%0d: got %h expected %h", e.idx, dut.register_file0.data[e.idx], e.val);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    exp_t e;
    prog = {rtype(7'b0000001, 5'd3, 5'd2, 3'd0, 5'd1),
            rtype(7'b0000001, 5'd4, 5'd3, 3'd0, 5'd2),
            rtype(7'b0000001, 5'd5, 5'd4, 3'd0, 5'd3)};
    setup();
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (dut.pc_q !== 32'h0) begin
      failures++; $display("FAIL midrun_pc: got %h expected %h", dut.pc_q, 32'h0);
    end
    checks++;
    if ({dut.if_valid_q, dut.id_ex_q.valid, dut.ex_wb_q.valid} !== 3'b000) begin
      failures++;
      $display("FAIL midrun_valids: got %b expected 000",
               {dut.if_valid_q, dut.id_ex_q.valid, dut.ex_wb_q.valid});
    end
    @(negedge clk);
    for (int i = 1; i <= 3; i++) begin
      checks++;
      if (dut.register_file0.data[i] !== 32'(i)) begin
        failures++;
        $display("FAIL midrun_partial x%0d: got %h expected %h", i, dut.register_file0.data[i], 32'(i));
      end
    end
    model[1] = 32'd6; model[2] = 32'd12; model[3] = 32'd20;
    push_model();
    release_and_run(13);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (dut.register_file0.data[e.idx] !== e.val) begin
        failures++;
        $display("FAIL midrun_final x%0d: got %h expected %h", e.idx, dut.register_file0.data[e.idx], e.val);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_dep_chain();
    test_x0_write();
    test_imm_shift_compare();
    test_zero_words();
    test_illegal_words();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
